digit_serial_adder: RTL and testbench



---
 rtl/digit_serial_adder_pkg.sv | 17 +
 rtl/digit_serial_adder_if.sv | 27 ++
 rtl/digit_serial_adder_digit_adder.sv | 23 ++
 rtl/digit_serial_adder.sv | 108 ++++++++++
 tb/tb_digit_serial_adder.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/digit_serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digit counter width; never below one bit so NDIG=1 still has a counter.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
    int unsigned ndig;
    ndig = width / digit;
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for digit_serial_adder.
interface digit_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from per-bit full-adder cells.
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/subtract: DIGIT bits per clock, LSB digit first, carry held in a flop.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  digit_serial_adder_if.slave bus
);
  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dsum;
  logic             dco, dmsb;
  logic [WIDTH-1:0] dsum_top;

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .x     (ra_q[DIGIT-1:0]),
    .y     (rb_q[DIGIT-1:0]),
    .ci    (c_q),
    .s     (dsum),
    .co    (dco),
    .c_msb (dmsb)
  );

  assign dsum_top = WIDTH'(dsum) << (WIDTH - DIGIT);

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          ra_d    = bus.a;
          rb_d    = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.cin ^ bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = (acc_q >> DIGIT) | dsum_top;
        ra_d  = ra_q >> DIGIT;
        rb_d  = rb_q >> DIGIT;
        c_d   = dco;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Last digit: carry into the MSB is used the same cycle, so no separate c_msb flop.
          state_d = DONE;
          sum_d   = acc_d;
          cout_d  = dco;
          ovf_d   = dmsb ^ dco;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three instances (DIGIT=4, 16, 1) against an arithmetic model.
module tb_digit_serial_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, busy;
  logic [2:0][15:0] a, b, sum;

  for (genvar g = 0; g < 3; g++) begin : g_u
    localparam int unsigned DG = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
    digit_serial_adder_if #(.WIDTH(16)) bus ();
    assign bus.in_valid  = in_valid[g];
    assign bus.a         = a[g];
    assign bus.b         = b[g];
    assign bus.cin       = cin[g];
    assign bus.sub       = sub[g];
    assign bus.out_ready = out_ready[g];
    assign in_ready[g]   = bus.in_ready;
    assign out_valid[g]  = bus.out_valid;
    assign sum[g]        = bus.sum;
    assign cout[g]       = bus.cout;
    assign ovf[g]        = bus.ovf;
    assign busy[g]       = bus.busy;
    digit_serial_adder #(.WIDTH(16), .DIGIT(DG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ndig_of(input int sel);
    return (sel == 0) ? 4 : ((sel == 1) ? 1 : 16);
  endfunction

  // Reference: plain integer arithmetic on the operand values; returns {cout, ovf, sum}.
  function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic ci, input logic sb);
    int sa, sbv, ua, ub, ic, r;
    logic c, o;
    sa  = $signed(av);
    sbv = $signed(bv);
    ua  = int'(av);
    ub  = int'(bv);
    ic  = ci ? 1 : 0;
    if (!sb) begin
      r = sa + sbv + ic;
      c = (ua + ub + ic) > 65535;
    end else begin
      r = sa - sbv - ic;
      c = ua >= (ub + ic);
    end
    o = (r > 32767) || (r < -32768);
    return {c, o, 16'(r)};
  endfunction

  task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb,
                        input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    in_valid[sel] = 1'b1;
    a[sel] = av; b[sel] = bv; cin[sel] = ci; sub[sel] = sb;
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    a[sel] = 16'($urandom); b[sel] = 16'($urandom);
    cin[sel] = 1'($urandom); sub[sel] = 1'($urandom);
    check_eq($sformatf("busy_after_accept u%0d", sel), 32'(busy[sel]), 32'd1);
    check_eq($sformatf("in_ready_in_run u%0d", sel), 32'(in_ready[sel]), 32'd0);
    lat = 0;
    while (!out_valid[sel] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq($sformatf("latency u%0d", sel), 32'(lat), 32'(ndig_of(sel)));
    check_eq($sformatf("sum u%0d %h%s%h", sel, av, sb ? "-" : "+", bv), 32'(sum[sel]), 32'(es));
    check_eq($sformatf("cout u%0d", sel), 32'(cout[sel]), 32'(ec));
    check_eq($sformatf("ovf u%0d", sel), 32'(ovf[sel]), 32'(eo));
    if (out_ready[sel]) begin
      @(posedge clk); #1;
      check_eq($sformatf("out_valid_drop u%0d", sel), 32'(out_valid[sel]), 32'd0);
      check_eq($sformatf("in_ready_idle u%0d", sel), 32'(in_ready[sel]), 32'd1);
    end
  endtask

  typedef struct {
    logic [15:0] av, bv;
    logic        ci, sb;
    logic [15:0] es;
    logic        ec, eo;
  } vec_t;

  vec_t dir[6] = '{
    '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0},
    '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1}
  };

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [17:0] m;
    logic [15:0] av, bv, held;
    logic        ci, sb;
    rst = 1'b1;
    in_valid = '0; cin = '0; sub = '0; out_ready = '1;
    a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check_eq($sformatf("rst in_ready u%0d", s), 32'(in_ready[s]), 32'd1);
      check_eq($sformatf("rst busy u%0d", s), 32'(busy[s]), 32'd0);
      check_eq($sformatf("rst out_valid u%0d", s), 32'(out_valid[s]), 32'd0);
      check_eq($sformatf("rst sum u%0d", s), 32'({cout[s], ovf[s], sum[s]}), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_op(0, dir[i].av, dir[i].bv, dir[i].ci, dir[i].sb, dir[i].es, dir[i].ec, dir[i].eo);

    // Backpressure on unit 0 while new operands are offered.
    out_ready[0] = 1'b0;
    run_op(0, 16'hA0B1, 16'h1C2D, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);
    held = sum[0];
    for (int k = 0; k < 5; k++) begin
      in_valid[0] = k[0] ? 1'b0 : 1'b1;
      a[0] = 16'h1111 * 16'(k + 1); b[0] = 16'h0F0F; sub[0] = 1'(k); cin[0] = 1'b1;
      @(posedge clk); #1;
      check_eq("bp out_valid", 32'(out_valid[0]), 32'd1);
      check_eq("bp in_ready", 32'(in_ready[0]), 32'd0);
      check_eq("bp sum stable", 32'({cout[0], ovf[0], sum[0]}), 32'({1'b0, 1'b0, 16'hBCDE}));
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check_eq("bp release out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("bp release in_ready", 32'(in_ready[0]), 32'd1);
    check_eq("bp no accept busy", 32'(busy[0]), 32'd0);
    check_eq("bp sum held", 32'(sum[0]), 32'(held));

    // Reset during the second RUN cycle.
    in_valid[0] = 1'b1; a[0] = 16'h1111; b[0] = 16'h2222; cin[0] = 1'b0; sub[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst busy", 32'(busy[0]), 32'd0);
    check_eq("midrst out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("midrst in_ready", 32'(in_ready[0]), 32'd1);
    check_eq("midrst sum", 32'(sum[0]), 32'd0);
    run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 15; i++) begin
        av = 16'($urandom); bv = 16'($urandom);
        ci = 1'($urandom); sb = 1'($urandom);
        if (i == 0) begin av = 16'h7FFF; bv = 16'h8000; sb = 1'b1; ci = 1'b0; end
        m = model(av, bv, ci, sb);
        run_op(s, av, bv, ci, sb, m[15:0], m[17], m[16]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
